// File: rtl/lsu_stb_pkg.sv
// Shared types for the LSU store buffer: entry layout, drain FSM states and address matching.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package lsu_stb_pkg;

   // Storage widths of one buffered store. Instances whose ADDR_W/DATA_W exceed
   // these would be truncated, so widen them here first if a wider LSU is built.
   localparam int STB_ADDR_W = 32;
   localparam int STB_DATA_W = 32;
   localparam int STB_SEL_W  = STB_DATA_W / 8;

   typedef struct packed {
      logic [STB_ADDR_W-1:0] addr;
      logic [STB_DATA_W-1:0] wdata;
      logic [STB_SEL_W-1:0]  sel;
      logic                  valid;
   } stb_entry_t;

   typedef enum logic {
      DR_IDLE = 1'b0,
      DR_REQ  = 1'b1
   } drain_state_t;

   // Byte offset within the word is ignored: stores and loads match per word.
   localparam logic [STB_ADDR_W-1:0] WORD_MASK = {{(STB_ADDR_W-2){1'b1}}, 2'b00};

   function automatic logic word_match(input logic [STB_ADDR_W-1:0] a,
                                       input logic [STB_ADDR_W-1:0] b);
      return ((a ^ b) & WORD_MASK) == '0;
   endfunction

endpackage

// File: rtl/lsu_stb_fwd_search.sv
// Youngest-first store-to-load forwarding search over the store buffer entries.
// Latency: combinational, results valid in the same cycle as ld_req.
// Backpressure: partial overlap raises ld_stall so the load retries later.
//
// Ports:
//   ents      in   entry array (circular, oldest at head_idx)
//   head_idx  in   index of the oldest entry
//   ld_req / ld_addr / ld_sel   in   load lookup
//   fwd_hit / fwd_data / ld_stall  out  lookup result
module lsu_stb_fwd_search
   import lsu_stb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  stb_entry_t          ents [DEPTH],
   input  logic [IDX_W-1:0]    head_idx,
   input  logic                ld_req,
   input  logic [ADDR_W-1:0]   ld_addr,
   input  logic [DATA_W/8-1:0] ld_sel,
   output logic                fwd_hit,
   output logic [DATA_W-1:0]   fwd_data,
   output logic                ld_stall
);

   logic [IDX_W-1:0]      idx;
   logic                  found;
   logic                  covers;
   logic [STB_DATA_W-1:0] match_data;

   // Walk from oldest to youngest; a later (younger) match overwrites an older
   // one, which gives youngest-match priority without a priority encoder.
   always_comb begin
      idx        = '0;
      found      = 1'b0;
      covers     = 1'b0;
      match_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_idx + IDX_W'(k);
         if (ents[idx].valid && word_match(ents[idx].addr, STB_ADDR_W'(ld_addr))) begin
            found      = 1'b1;
            covers     = ((ents[idx].sel & STB_SEL_W'(ld_sel)) == STB_SEL_W'(ld_sel));
            match_data = ents[idx].wdata;
         end
      end
   end

   assign fwd_hit  = ld_req & found & covers;
   assign ld_stall = ld_req & found & ~covers;
   assign fwd_data = fwd_hit ? DATA_W'(match_data) : '0;

endmodule

// File: rtl/lsu_store_buffer.sv
// Store buffer between LSU and D-cache: DEPTH-entry FIFO, in-order drain, load forwarding, fence drain.
// Latency: store ack one cycle after accept; drain req one cycle after the buffer becomes non-empty.
// Backpressure: stall (comb) when full on the registered count or while flush_req is high.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   lsu2stb_req/addr/wdata/sel     store request; stb2lsu_ack (registered), stb2lsu_stall (comb)
//   lsu2stb_ld_req/ld_addr/ld_sel  load lookup; stb2lsu_fwd_hit/fwd_data/ld_stall
//   lsu2stb_flush_req              fence; stb2lsu_flush_done when empty and drain idle
//   stb2dcache_req/addr/wdata/sel  head-entry drain request, dcache2stb_ack pops it
//   stb_empty, stb_full, stb_count status
module lsu_store_buffer
   import lsu_stb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   lsu2stb_req,
   input  logic [ADDR_W-1:0]      lsu2stb_addr,
   input  logic [DATA_W-1:0]      lsu2stb_wdata,
   input  logic [DATA_W/8-1:0]    lsu2stb_sel,
   output logic                   stb2lsu_ack,
   output logic                   stb2lsu_stall,
   input  logic                   lsu2stb_ld_req,
   input  logic [ADDR_W-1:0]      lsu2stb_ld_addr,
   input  logic [DATA_W/8-1:0]    lsu2stb_ld_sel,
   output logic                   stb2lsu_fwd_hit,
   output logic [DATA_W-1:0]      stb2lsu_fwd_data,
   output logic                   stb2lsu_ld_stall,
   input  logic                   lsu2stb_flush_req,
   output logic                   stb2lsu_flush_done,
   output logic                   stb2dcache_req,
   output logic [ADDR_W-1:0]      stb2dcache_addr,
   output logic [DATA_W-1:0]      stb2dcache_wdata,
   output logic [DATA_W/8-1:0]    stb2dcache_sel,
   input  logic                   dcache2stb_ack,
   output logic                   stb_empty,
   output logic                   stb_full,
   output logic [$clog2(DEPTH):0] stb_count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   stb_entry_t       entries [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   drain_state_t     state;
   drain_state_t     state_nxt;
   logic             drain_req;
   logic             accept;
   logic             pop;

   assign wr_idx = wr_ptr[IDX_W-1:0];
   assign rd_idx = rd_ptr[IDX_W-1:0];

   // Extra pointer MSB is the wrap bit: same index with differing wrap bits is full.
   assign stb_empty = (wr_ptr == rd_ptr);
   assign stb_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_idx == rd_idx);
   assign stb_count = wr_ptr - rd_ptr;

   // Full comes from registered pointers, so a same-cycle pop never frees a slot
   // for a store in that cycle; this keeps stall off the dcache ack path.
   assign accept        = lsu2stb_req & ~stb_full & ~lsu2stb_flush_req;
   assign stb2lsu_stall = lsu2stb_req & (stb_full | lsu2stb_flush_req);
   assign pop           = drain_req & dcache2stb_ack;

   assign stb2lsu_flush_done = lsu2stb_flush_req & stb_empty & (state == DR_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         stb2lsu_ack <= 1'b0;
         state       <= DR_IDLE;
         for (int k = 0; k < DEPTH; k++) begin
            entries[k] <= '0;
         end
      end else begin
         stb2lsu_ack <= accept;
         state       <= state_nxt;
         // Accept and pop never target the same slot: accept needs ~full, pop needs ~empty
         // and the slots only coincide in those two cases.
         if (accept) begin
            entries[wr_idx] <= '{addr:  STB_ADDR_W'(lsu2stb_addr),
                                 wdata: STB_DATA_W'(lsu2stb_wdata),
                                 sel:   STB_SEL_W'(lsu2stb_sel),
                                 valid: 1'b1};
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            entries[rd_idx].valid <= 1'b0;
            rd_ptr                <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // Drain FSM: request stays up back-to-back while more than the head remains.
   always_comb begin
      state_nxt = state;
      drain_req = 1'b0;
      case (state)
         DR_IDLE: begin
            if (!stb_empty) begin
               state_nxt = DR_REQ;
            end
         end
         DR_REQ: begin
            drain_req = 1'b1;
            if (dcache2stb_ack) begin
               state_nxt = (stb_count > PTR_W'(1)) ? DR_REQ : DR_IDLE;
            end
         end
         default: state_nxt = DR_IDLE;
      endcase
   end

   assign stb2dcache_req   = drain_req;
   assign stb2dcache_addr  = drain_req ? ADDR_W'(entries[rd_idx].addr)      : '0;
   assign stb2dcache_wdata = drain_req ? DATA_W'(entries[rd_idx].wdata)     : '0;
   assign stb2dcache_sel   = drain_req ? (DATA_W/8)'(entries[rd_idx].sel)   : '0;

   lsu_stb_fwd_search #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fwd_search (
      .ents     (entries),
      .head_idx (rd_idx),
      .ld_req   (lsu2stb_ld_req),
      .ld_addr  (lsu2stb_ld_addr),
      .ld_sel   (lsu2stb_ld_sel),
      .fwd_hit  (stb2lsu_fwd_hit),
      .fwd_data (stb2lsu_fwd_data),
      .ld_stall (stb2lsu_ld_stall)
   );

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Bench for lsu_store_buffer: queue-based reference model checked every cycle plus directed literals.
module tb_lsu_store_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lsu2stb_req = 1'b0;
   logic [31:0] lsu2stb_addr = '0;
   logic [31:0] lsu2stb_wdata = '0;
   logic [3:0]  lsu2stb_sel = '0;
   logic        stb2lsu_ack;
   logic        stb2lsu_stall;
   logic        lsu2stb_ld_req = 1'b0;
   logic [31:0] lsu2stb_ld_addr = '0;
   logic [3:0]  lsu2stb_ld_sel = '0;
   logic        stb2lsu_fwd_hit;
   logic [31:0] stb2lsu_fwd_data;
   logic        stb2lsu_ld_stall;
   logic        lsu2stb_flush_req = 1'b0;
   logic        stb2lsu_flush_done;
   logic        stb2dcache_req;
   logic [31:0] stb2dcache_addr;
   logic [31:0] stb2dcache_wdata;
   logic [3:0]  stb2dcache_sel;
   logic        dcache2stb_ack = 1'b0;
   logic        stb_empty;
   logic        stb_full;
   logic [2:0]  stb_count;

   always #5 clk = ~clk;

   lsu_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
      .clk                (clk),
      .rst                (rst),
      .lsu2stb_req        (lsu2stb_req),
      .lsu2stb_addr       (lsu2stb_addr),
      .lsu2stb_wdata      (lsu2stb_wdata),
      .lsu2stb_sel        (lsu2stb_sel),
      .stb2lsu_ack        (stb2lsu_ack),
      .stb2lsu_stall      (stb2lsu_stall),
      .lsu2stb_ld_req     (lsu2stb_ld_req),
      .lsu2stb_ld_addr    (lsu2stb_ld_addr),
      .lsu2stb_ld_sel     (lsu2stb_ld_sel),
      .stb2lsu_fwd_hit    (stb2lsu_fwd_hit),
      .stb2lsu_fwd_data   (stb2lsu_fwd_data),
      .stb2lsu_ld_stall   (stb2lsu_ld_stall),
      .lsu2stb_flush_req  (lsu2stb_flush_req),
      .stb2lsu_flush_done (stb2lsu_flush_done),
      .stb2dcache_req     (stb2dcache_req),
      .stb2dcache_addr    (stb2dcache_addr),
      .stb2dcache_wdata   (stb2dcache_wdata),
      .stb2dcache_sel     (stb2dcache_sel),
      .dcache2stb_ack     (dcache2stb_ack),
      .stb_empty          (stb_empty),
      .stb_full           (stb_full),
      .stb_count          (stb_count)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   // ---------------- reference model: a plain queue of pending stores ----------------
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  sel;
   } ment_t;

   ment_t       mq[$];
   logic        m_ack   = 1'b0;
   logic        m_drain = 1'b0;   // a drain request is outstanding to the cache
   logic [31:0] drained[$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_ack   <= 1'b0;
         m_drain <= 1'b0;
      end else begin
         m_ack <= lsu2stb_req && !lsu2stb_flush_req && (mq.size() < DEPTH);
         if (m_drain) m_drain <= dcache2stb_ack ? (mq.size() > 1) : 1'b1;
         else         m_drain <= (mq.size() > 0);
         if (lsu2stb_req && !lsu2stb_flush_req && mq.size() < DEPTH)
            mq.push_back('{addr: lsu2stb_addr, data: lsu2stb_wdata, sel: lsu2stb_sel});
         if (m_drain && dcache2stb_ack && mq.size() > 0)
            void'(mq.pop_front());
      end
   end

   logic        e_hit, e_lds;
   logic [31:0] e_data;

   function automatic void exp_fwd(output logic hit, output logic lds, output logic [31:0] d);
      hit = 1'b0; lds = 1'b0; d = '0;
      if (lsu2stb_ld_req) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].addr[31:2] == lsu2stb_ld_addr[31:2]) begin
               if ((mq[i].sel & lsu2stb_ld_sel) == lsu2stb_ld_sel) begin
                  hit = 1'b1;
                  d   = mq[i].data;
               end else begin
                  lds = 1'b1;
               end
               break;
            end
         end
      end
   endfunction

   // Compare process: outputs sampled on the falling edge, away from state updates.
   always @(negedge clk) begin
      exp_fwd(e_hit, e_lds, e_data);
      chk("m_stall", stb2lsu_stall, lsu2stb_req && (mq.size() == DEPTH || lsu2stb_flush_req));
      chk("m_ack", stb2lsu_ack, m_ack);
      chk("m_count", stb_count, mq.size());
      chk("m_empty", stb_empty, mq.size() == 0);
      chk("m_full", stb_full, mq.size() == DEPTH);
      chk("m_flush_done", stb2lsu_flush_done, lsu2stb_flush_req && mq.size() == 0 && !m_drain);
      chk("m_dreq", stb2dcache_req, m_drain);
      if (m_drain && mq.size() > 0) begin
         chk("m_daddr", stb2dcache_addr, mq[0].addr);
         chk("m_ddata", stb2dcache_wdata, mq[0].data);
         chk("m_dsel", stb2dcache_sel, mq[0].sel);
      end
      chk("m_fwd_hit", stb2lsu_fwd_hit, e_hit);
      chk("m_ld_stall", stb2lsu_ld_stall, e_lds);
      if (e_hit) chk("m_fwd_data", stb2lsu_fwd_data, e_data);
      if (!rst && stb2dcache_req && dcache2stb_ack) drained.push_back(stb2dcache_addr);
   end

   // ---------------- stimulus helpers ----------------
   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      lsu2stb_req = 1'b1; lsu2stb_addr = a; lsu2stb_wdata = d; lsu2stb_sel = s;
      #1;
      while (stb2lsu_stall && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("store_wait_bound", n < 50, 1);
      @(posedge clk); #1;
      lsu2stb_req = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((!stb_empty || stb2dcache_req) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_bound", n < 40, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end, required completion");
      $fatal(1);
   end

   logic [31:0] exp_a;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_empty", stb_empty, 1);
      chk("rst_count", stb_count, 0);
      chk("rst_dreq", stb2dcache_req, 0);
      chk("rst_daddr", stb2dcache_addr, 0);
      chk("rst_ack", stb2lsu_ack, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: fill without drain acks
      for (int i = 0; i < 4; i++) begin
         exp_a = 32'h1000 + 32'(16 * i);
         store(exp_a, 32'hD000_0000 + 32'(i), 4'hF >> i);
         chk("t1_ack", stb2lsu_ack, 1);
      end
      chk("t1_full", stb_full, 1);
      chk("t1_count", stb_count, 4);
      chk("t1_head", stb2dcache_addr, 32'h1000);
      lsu2stb_req = 1'b1; lsu2stb_addr = 32'h1040;
      #1;
      chk("t1_stall5", stb2lsu_stall, 1);
      @(posedge clk); #1;
      lsu2stb_req = 1'b0;
      chk("t1_count5", stb_count, 4);
      chk("t1_noack5", stb2lsu_ack, 0);

      // 2: drain in order
      drained.delete();
      dcache2stb_ack = 1'b1;
      wait_drain();
      dcache2stb_ack = 1'b0;
      chk("t2_ndrained", drained.size(), 4);
      chk("t2_a0", drained[0], 32'h1000);
      chk("t2_a1", drained[1], 32'h1010);
      chk("t2_a2", drained[2], 32'h1020);
      chk("t2_a3", drained[3], 32'h1030);
      chk("t2_empty", stb_empty, 1);
      chk("t2_req_low", stb2dcache_req, 0);

      // 3: forwarding
      store(32'h100, 32'hAABB_CCDD, 4'hF);
      store(32'h100, 32'h0000_0011, 4'h1);
      lsu2stb_ld_req = 1'b1; lsu2stb_ld_addr = 32'h100; lsu2stb_ld_sel = 4'h1;
      #1;
      chk("t3_hit", stb2lsu_fwd_hit, 1);
      chk("t3_data", stb2lsu_fwd_data, 32'h11);
      chk("t3_nostall", stb2lsu_ld_stall, 0);
      lsu2stb_ld_sel = 4'hF;
      #1;
      chk("t3_partial_stall", stb2lsu_ld_stall, 1);
      chk("t3_partial_nohit", stb2lsu_fwd_hit, 0);
      lsu2stb_ld_addr = 32'h102; lsu2stb_ld_sel = 4'h1;
      #1;
      chk("t3_lowbits_hit", stb2lsu_fwd_hit, 1);
      lsu2stb_ld_sel = 4'h2;
      #1;
      chk("t3_youngest_stall", stb2lsu_ld_stall, 1);
      lsu2stb_ld_addr = 32'h104; lsu2stb_ld_sel = 4'hF;
      #1;
      chk("t3_miss_hit", stb2lsu_fwd_hit, 0);
      chk("t3_miss_stall", stb2lsu_ld_stall, 0);
      lsu2stb_ld_addr = 32'h100; lsu2stb_ld_sel = 4'h1; lsu2stb_ld_req = 1'b0;
      #1;
      chk("t3_noreq_hit", stb2lsu_fwd_hit, 0);
      dcache2stb_ack = 1'b1;
      wait_drain();
      dcache2stb_ack = 1'b0;

      // 4: full buffer, store and drain ack in the same cycle
      drained.delete();
      for (int i = 0; i < 4; i++) store(32'h3000 + 32'(4 * i) + 32'h100, 32'h30 + 32'(i), 4'hF);
      @(posedge clk); #1;
      chk("t4_dreq", stb2dcache_req, 1);
      lsu2stb_req = 1'b1; lsu2stb_addr = 32'h3000; lsu2stb_wdata = 32'h3F; lsu2stb_sel = 4'hC;
      dcache2stb_ack = 1'b1;
      #1;
      chk("t4_stall_same_cycle", stb2lsu_stall, 1);
      @(posedge clk); #1;
      chk("t4_count3", stb_count, 3);
      chk("t4_noack", stb2lsu_ack, 0);
      dcache2stb_ack = 1'b0;
      #1;
      chk("t4_retry_nostall", stb2lsu_stall, 0);
      @(posedge clk); #1;
      lsu2stb_req = 1'b0;
      chk("t4_retry_ack", stb2lsu_ack, 1);
      chk("t4_count4", stb_count, 4);
      dcache2stb_ack = 1'b1;
      wait_drain();
      dcache2stb_ack = 1'b0;
      chk("t4_last_drained", drained[drained.size()-1], 32'h3000);

      // 5: flush
      drained.delete();
      store(32'h4000, 32'h40, 4'hF);
      store(32'h4004, 32'h41, 4'hF);
      lsu2stb_flush_req = 1'b1;
      lsu2stb_req = 1'b1; lsu2stb_addr = 32'h4008;
      #1;
      chk("t5_stall", stb2lsu_stall, 1);
      chk("t5_not_done", stb2lsu_flush_done, 0);
      dcache2stb_ack = 1'b1;
      begin
         int n = 0;
         while (!stb2lsu_flush_done && n < 40) begin
            @(posedge clk); #1;
            n++;
         end
         chk("t5_bound", n < 40, 1);
      end
      chk("t5_two_acks", drained.size(), 2);
      chk("t5_count", stb_count, 0);
      chk("t5_idle", stb2dcache_req, 0);
      lsu2stb_req = 1'b0; lsu2stb_flush_req = 1'b0; dcache2stb_ack = 1'b0;
      @(posedge clk); #1;

      // 6: reset mid-drain, then wrap pointers
      for (int i = 0; i < 3; i++) store(32'h5000 + 32'(4 * i), 32'h50 + 32'(i), 4'hF);
      @(posedge clk); #1;
      chk("t6_dreq", stb2dcache_req, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_req", stb2dcache_req, 0);
      chk("t6_rst_empty", stb_empty, 1);
      chk("t6_rst_count", stb_count, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      drained.delete();
      dcache2stb_ack = 1'b1;
      for (int i = 0; i < 9; i++) store(32'h6000 + 32'(4 * i), 32'h60 + 32'(i), 4'hF);
      wait_drain();
      dcache2stb_ack = 1'b0;
      chk("t6_ndrained", drained.size(), 9);
      for (int i = 0; i < 9; i++) begin
         exp_a = 32'h6000 + 32'(4 * i);
         chk("t6_order", drained[i], exp_a);
      end

      @(posedge clk); #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
